// File: rtl/regbank_writeback.sv
// Write-port arbiter for the 32x32 register bank: execute results bypass, long-latency results queue.
// Optional WB_FORWARD_EN adds decode-side forwarding of the write landing at the next edge.
module regbank_writeback #(
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             exec_valid_i,
  input  logic [4:0]       exec_rd_i,
  input  logic [31:0]      exec_data_i,
  input  logic             ll_valid_i,
  output logic             ll_ready_o,
  input  logic [4:0]       ll_rd_i,
  input  logic [31:0]      ll_data_i,
  input  logic             issue_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic             hazard_o,
  output logic [4:0]       rd_o,
  output logic             enable_o,
  output logic [31:0]      data_o,
  output logic [CNT_W-1:0] fifo_count_o
`ifdef WB_FORWARD_EN
  ,
  input  logic [31:0]      rf_data1_i,
  input  logic [31:0]      rf_data2_i,
  output logic [31:0]      fwd1_o,
  output logic [31:0]      fwd2_o
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t          mem [FIFO_DEPTH];
  wb_ent_t          head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending, pending_d;
  logic             push, pop;

  assign ll_ready_o   = (count < DEPTH_C);
  assign push         = ll_valid_i && ll_ready_o;
  // execute always wins the port; the FIFO only drains on idle execute cycles
  assign pop          = !exec_valid_i && (count != '0);
  assign head         = mem[rd_ptr];
  assign fifo_count_o = count;
  assign hazard_o     = pending[rs1_i] | pending[rs2_i];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: ll_rd_i, data: ll_data_i};
  end

  // set after clear so a re-issue in the pop cycle keeps the register pending
  always_comb begin
    pending_d = pending;
    if (pop && head.rd != '0) pending_d[head.rd] = 1'b0;
    if (issue_i && issue_rd_i != '0) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      rd_o     <= '0;
      enable_o <= 1'b0;
      data_o   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (exec_valid_i) begin
        rd_o     <= exec_rd_i;
        data_o   <= exec_data_i;
        enable_o <= (exec_rd_i != '0);
      end else if (pop) begin
        rd_o     <= head.rd;
        data_o   <= head.data;
        enable_o <= (head.rd != '0);
      end else begin
        enable_o <= 1'b0;
      end
      pending <= pending_d;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd1_o = (enable_o && rd_o == rs1_i && rs1_i != '0) ? data_o : rf_data1_i;
  assign fwd2_o = (enable_o && rd_o == rs2_i && rs2_i != '0) ? data_o : rf_data2_i;
`endif
endmodule
